// File: rtl/pc_sequencer_if.sv
// Bundle of the control, operand and status signals between the decode/branch logic and the
// program-counter stage. The master side drives instruction control and operands. The slave
// side (the sequencer) returns the PC, its status flags and the perf counters.
interface pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             take_branch;
    logic             jump;
    logic             jalr;
    logic             halt_req;
    logic             stall;
    logic [31:0]      imm;
    logic [31:0]      rs1_data;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             instr_valid;
    logic             halted;
    logic             misaligned;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output take_branch, jump, jalr, halt_req, stall, imm, rs1_data,
        input  pc, pc_plus4, instr_valid, halted, misaligned, retired_cnt, taken_cnt
    );

    modport slave (
        input  take_branch, jump, jalr, halt_req, stall, imm, rs1_data,
        output pc, pc_plus4, instr_valid, halted, misaligned, retired_cnt, taken_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage.
// - Holds the architectural PC and picks the next PC: sequential, branch, JAL or JALR.
// - A taken target with bits[1:0] != 0 freezes the PC, sets the sticky misaligned flag and halts.
// - Counts retired instructions and taken control transfers.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             misaligned_q, misaligned_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             instr_valid_q;
    logic             halted_q;

    logic [31:0]      br_tgt;
    logic [31:0]      jalr_tgt;
    logic [31:0]      sel_tgt;
    logic             xfer;

    // Target arithmetic. JALR has precedence over JAL and conditional branches.
    always_comb begin
        br_tgt   = pc_q + bus.imm;
        jalr_tgt = (bus.rs1_data + bus.imm) & ~32'h1;
        sel_tgt  = bus.jalr ? jalr_tgt : br_tgt;
        xfer     = bus.jalr | bus.jump | bus.take_branch;
    end

    // Next-state, next-PC and counter selection. Only an unstalled RUN cycle changes anything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misaligned_d  = misaligned_q;
        retired_cnt_d = retired_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!bus.stall) begin
                    // The halting or faulting instruction still retires.
                    retired_cnt_d = retired_cnt_q + CNT_ONE;
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (xfer) begin
                        if (sel_tgt[1:0] != 2'b00) begin
                            misaligned_d = 1'b1;
                            state_d      = HALT;
                        end else begin
                            pc_d        = sel_tgt;
                            taken_cnt_d = taken_cnt_q + CNT_ONE;
                        end
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: state_d = HALT;
        endcase
    end

    // State register and registered status outputs. Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            misaligned_q  <= 1'b0;
            retired_cnt_q <= '0;
            taken_cnt_q   <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            misaligned_q  <= misaligned_d;
            retired_cnt_q <= retired_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
            instr_valid_q <= (state_d == RUN);
            halted_q      <= (state_d == HALT);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + 32'd4;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = halted_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.retired_cnt = retired_cnt_q;
    assign bus.taken_cnt   = taken_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Each step drives one cycle of inputs and pushes the expected
// outputs onto a scoreboard queue. After the clock edge the entry is popped and compared.
module tb_pc_sequencer;
    logic clk;
    logic rst;

    pc_sequencer_if #(.CNT_W(32)) bus ();

    pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        instr_valid;
        logic        halted;
        logic        misaligned;
        logic [31:0] retired;
        logic [31:0] taken;
    } exp_t;

    exp_t sb_q[$];

    int tests  = 0;
    int failed = 0;

    // Reference state (0=BOOT, 1=RUN, 2=HALT)
    logic [31:0] m_pc;
    int          m_st;
    logic        m_mis;
    logic [31:0] m_ret;
    logic [31:0] m_tak;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic st, input logic hr, input logic jp,
                         input logic jr, input logic br, input logic [31:0] im,
                         input logic [31:0] rs);
        logic [31:0] tgt;
        if (r) begin
            m_pc = 32'h0; m_st = 0; m_mis = 1'b0; m_ret = 32'h0; m_tak = 32'h0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1 && !st) begin
            m_ret = m_ret + 32'd1;
            if (hr) begin
                m_st = 2;
            end else if (jr || jp || br) begin
                tgt = jr ? ((rs + im) & 32'hFFFF_FFFE) : (m_pc + im);
                if (tgt[1:0] != 2'b00) begin
                    m_mis = 1'b1;
                    m_st  = 2;
                end else begin
                    m_pc  = tgt;
                    m_tak = m_tak + 32'd1;
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic st, input logic hr,
                        input logic jp, input logic jr, input logic br,
                        input logic [31:0] im, input logic [31:0] rs);
        exp_t e;
        rst             = r;
        bus.stall       = st;
        bus.halt_req    = hr;
        bus.jump        = jp;
        bus.jalr        = jr;
        bus.take_branch = br;
        bus.imm         = im;
        bus.rs1_data    = rs;
        model(r, st, hr, jp, jr, br, im, rs);
        e.pc          = m_pc;
        e.pc_plus4    = m_pc + 32'd4;
        e.instr_valid = (m_st == 1);
        e.halted      = (m_st == 2);
        e.misaligned  = m_mis;
        e.retired     = m_ret;
        e.taken       = m_tak;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".pc"},          bus.pc,                  e.pc);
        check({tag, ".pc_plus4"},    bus.pc_plus4,            e.pc_plus4);
        check({tag, ".instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, e.instr_valid});
        check({tag, ".halted"},      {31'h0, bus.halted},      {31'h0, e.halted});
        check({tag, ".misaligned"},  {31'h0, bus.misaligned},  {31'h0, e.misaligned});
        check({tag, ".retired"},     bus.retired_cnt,         e.retired);
        check({tag, ".taken"},       bus.taken_cnt,           e.taken);
        $display("[TB] %s pc=%h iv=%0b halt=%0b mis=%0b ret=%0d tak=%0d", tag, bus.pc,
                 bus.instr_valid, bus.halted, bus.misaligned, bus.retired_cnt, bus.taken_cnt);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0; bus.halt_req = 1'b0; bus.jump = 1'b0; bus.jalr = 1'b0;
        bus.take_branch = 1'b0; bus.imm = 32'h0; bus.rs1_data = 32'h0;
        m_pc = 32'h0; m_st = 0; m_mis = 1'b0; m_ret = 32'h0; m_tak = 32'h0;

        // 1. Reset and sequential flow
        step("rst0", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("rst1", 1, 0, 1, 1, 1, 1, 32'h4, 32'h8);
        step("boot", 0, 0, 1, 1, 0, 1, 32'h8, 32'h0);
        check("boot_pc_zero", bus.pc, 32'h0);
        step("seq4", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("seq8", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("seqC", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("seqC_pc", bus.pc, 32'hC);
        check("seqC_ret3", bus.retired_cnt, 32'd3);
        step("seq10", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        // 2. Branch taken backwards, then forward back, then not taken
        step("br_m8", 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 32'h0);
        check("br_m8_pc", bus.pc, 32'h8);
        check("br_m8_tak", bus.taken_cnt, 32'd1);
        step("br_p8", 0, 0, 0, 0, 0, 1, 32'h8, 32'h0);
        step("nt14", 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);
        check("nt14_pc", bus.pc, 32'h14);

        // 3. JALR with misaligned target halts with pc held
        step("jalr_mis", 0, 0, 0, 1, 1, 1, 32'h4, 32'h103);
        check("jalr_mis_pc", bus.pc, 32'h14);
        check("jalr_mis_flag", {31'h0, bus.misaligned}, 32'h1);
        step("mis_hold", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("rst2", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("boot2", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("jalr_ok", 0, 0, 0, 1, 1, 1, 32'h4, 32'h101);
        check("jalr_ok_pc", bus.pc, 32'h104);

        // 4. Stall freezes everything, including halt/jump requests
        step("stall0", 0, 1, 0, 0, 0, 1, 32'h40, 32'h0);
        step("stall1", 0, 1, 1, 1, 0, 1, 32'h40, 32'h0);
        step("stall2", 0, 1, 0, 0, 0, 1, 32'h40, 32'h0);
        check("stall2_pc", bus.pc, 32'h104);
        step("unstall", 0, 0, 0, 0, 0, 0, 32'h40, 32'h0);
        check("unstall_pc", bus.pc, 32'h108);

        // 5. Halt at 0x20, later jumps ignored
        step("to20", 0, 0, 0, 0, 1, 0, 32'h0, 32'h20);
        step("halt", 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        check("halt_pc", bus.pc, 32'h20);
        check("halt_flag", {31'h0, bus.halted}, 32'h1);
        step("hj0", 0, 0, 0, 1, 0, 0, 32'h100, 32'h0);
        step("hj1", 0, 0, 0, 1, 1, 1, 32'h100, 32'h200);

        // 6. PC wrap, misaligned branch, reset during stall in HALT
        step("rst3", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("boot3", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("toFFFC", 0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("wrap_pc", bus.pc, 32'h0);
        step("br_mis", 0, 0, 0, 0, 0, 1, 32'h2, 32'h0);
        step("rst_stall", 1, 1, 1, 1, 1, 1, 32'h8, 32'h8);
        check("rst_stall_ret", bus.retired_cnt, 32'd0);
        step("boot4", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step("seq_end", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        tests++;
        assert (sb_q.size() == 0) else begin
            failed++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
